// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle control FSM for the CPU datapath. It latches the Op/Func fields
//   during FETCH and then walks FETCH -> DECODE -> EXEC -> MEM -> WB as the
//   instruction requires, driving the datapath select and strobe inputs.
//   A data-memory wait counter forces the sticky FAULT state when DMReady stays
//   low for MEM_TIMEOUT consecutive MEM cycles.
//
//   Parameters
//     MEM_TIMEOUT  consecutive DMReady-low MEM cycles before FAULT (1..255)
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-low reset
//     Op, Func   in   instruction fields, captured at the end of FETCH
//     DMReady    in   data memory completes the current access this cycle
//     IRWrite    out  latch instruction word (FETCH)
//     PCWrite    out  load PC from NPC (retiring state only)
//     RegWrite   out  GRF write enable
//     MemWrite   out  DM write enable
//     MemRead    out  DM read request
//     RegDstSel  out  0=Rt 1=Rd 2=31
//     ALUSrcSel  out  0=GRFRD2 1=EXTO
//     toRegSel   out  0=ALU 1=DM 2=EXTO 3=PC4
//     NPCOp      out  0=PC+4 1=beq 2=j/jal 3=jr
//     ALUOp      out  0=add 1=sub 2=or
//     EXTOp      out  0=zero 1=sign 2=lui
//     DMType     out  0=word 1=byte
//     Retire     out  pulse on the final state of each instruction
//     Illegal    out  pulse in DECODE for unsupported Op/Func
//     MemFault   out  sticky memory-timeout flag, cleared only by reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       DMReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic [2:0] RegDstSel,
    output logic [2:0] ALUSrcSel,
    output logic [2:0] toRegSel,
    output logic [2:0] NPCOp,
    output logic [3:0] ALUOp,
    output logic [2:0] EXTOp,
    output logic [2:0] DMType,
    output logic       Retire,
    output logic       Illegal,
    output logic       MemFault
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_JR, I_ORI, I_LUI, I_LW, I_LB,
        I_SW, I_SB, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [5:0] r_op;
    logic [5:0] r_func;
    logic [7:0] r_cnt;
    instr_t     w_instr;
    logic       w_load;
    logic       w_mem;

    function automatic instr_t decode(input logic [5:0] op, input logic [5:0] func);
        instr_t d;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100000: d = I_ADD;
                    6'b100010: d = I_SUB;
                    6'b001000: d = I_JR;
                    default:   d = I_ILL;
                endcase
            end
            6'b001101: d = I_ORI;
            6'b001111: d = I_LUI;
            6'b100011: d = I_LW;
            6'b100000: d = I_LB;
            6'b101011: d = I_SW;
            6'b101000: d = I_SB;
            6'b000100: d = I_BEQ;
            6'b000010: d = I_J;
            6'b000011: d = I_JAL;
            default:   d = I_ILL;
        endcase
        return d;
    endfunction

    assign w_instr = decode(r_op, r_func);
    assign w_load  = (w_instr == I_LW) || (w_instr == I_LB);
    assign w_mem   = w_load || (w_instr == I_SW) || (w_instr == I_SB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_func  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_op    <= Op;
                    r_func  <= Func;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_instr == I_ILL)
                        r_state <= S_FETCH;
                    else if (w_instr == I_J || w_instr == I_JAL)
                        r_state <= S_WB;
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_mem)
                        r_state <= S_MEM;
                    else if (w_instr == I_BEQ || w_instr == I_JR)
                        r_state <= S_FETCH;
                    else
                        r_state <= S_WB;
                end
                S_MEM: begin
                    if (DMReady) begin
                        r_cnt   <= '0;
                        r_state <= w_load ? S_WB : S_FETCH;
                    end else if (r_cnt == LP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FAULT;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_irwrite, w_pcwrite, w_regwrite, w_memwrite, w_memread;
    logic       w_retire, w_illegal, w_memfault;
    logic [2:0] w_regdst, w_alusrc, w_toreg, w_npcop, w_extop, w_dmtype;
    logic [3:0] w_aluop;

    // Moore decode of state and latched fields; the only input dependence is
    // DMReady, which lets a store retire in the MEM cycle that completes it.
    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_memread  = 1'b0;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        w_memfault = 1'b0;
        w_regdst   = 3'd0;
        w_alusrc   = 3'd0;
        w_toreg    = 3'd0;
        w_npcop    = 3'd0;
        w_aluop    = 4'd0;
        w_extop    = 3'd0;
        w_dmtype   = 3'd0;
        case (r_state)
            S_FETCH: w_irwrite = 1'b1;
            S_DECODE: begin
                if (w_instr == I_ILL) begin
                    w_illegal = 1'b1;
                    w_pcwrite = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_EXEC: begin
                case (w_instr)
                    I_SUB: w_aluop = 4'd1;
                    I_ORI: begin w_aluop = 4'd2; w_alusrc = 3'd1; end
                    I_LUI: begin w_alusrc = 3'd1; w_extop = 3'd2; end
                    I_LW, I_LB, I_SW, I_SB: begin w_alusrc = 3'd1; w_extop = 3'd1; end
                    I_BEQ: begin
                        w_aluop   = 4'd1;
                        w_extop   = 3'd1;
                        w_pcwrite = 1'b1;
                        w_npcop   = 3'd1;
                        w_retire  = 1'b1;
                    end
                    I_JR: begin
                        w_pcwrite = 1'b1;
                        w_npcop   = 3'd3;
                        w_retire  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address path held stable for the whole access.
                w_alusrc  = 3'd1;
                w_extop   = 3'd1;
                w_dmtype  = (w_instr == I_LB || w_instr == I_SB) ? 3'd1 : 3'd0;
                w_memread = w_load;
                w_memwrite = !w_load;
                if (!w_load && DMReady) begin
                    w_pcwrite = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_WB: begin
                w_pcwrite  = 1'b1;
                w_retire   = 1'b1;
                w_regwrite = 1'b1;
                case (w_instr)
                    I_ADD: w_regdst = 3'd1;
                    I_SUB: begin w_regdst = 3'd1; w_aluop = 4'd1; end
                    I_ORI: begin w_aluop = 4'd2; w_alusrc = 3'd1; end
                    I_LUI: begin w_alusrc = 3'd1; w_extop = 3'd2; w_toreg = 3'd2; end
                    I_LW:  w_toreg = 3'd1;
                    I_LB:  begin w_toreg = 3'd1; w_dmtype = 3'd1; end
                    I_J:   begin w_regwrite = 1'b0; w_npcop = 3'd2; end
                    I_JAL: begin w_regdst = 3'd2; w_toreg = 3'd3; w_npcop = 3'd2; end
                    default: ;
                endcase
            end
            S_FAULT: w_memfault = 1'b1;
            default: ;
        endcase
    end

    // The state register already sits in FETCH while reset is held, so the
    // outputs are forced low by reset itself; IRWrite rises as soon as reset
    // releases, giving FETCH its strobe in the very first cycle.
    assign IRWrite   = reset & w_irwrite;
    assign PCWrite   = reset & w_pcwrite;
    assign RegWrite  = reset & w_regwrite;
    assign MemWrite  = reset & w_memwrite;
    assign MemRead   = reset & w_memread;
    assign Retire    = reset & w_retire;
    assign Illegal   = reset & w_illegal;
    assign MemFault  = reset & w_memfault;
    assign RegDstSel = reset ? w_regdst : 3'd0;
    assign ALUSrcSel = reset ? w_alusrc : 3'd0;
    assign toRegSel  = reset ? w_toreg  : 3'd0;
    assign NPCOp     = reset ? w_npcop  : 3'd0;
    assign ALUOp     = reset ? w_aluop  : 4'd0;
    assign EXTOp     = reset ? w_extop  : 3'd0;
    assign DMType    = reset ? w_dmtype : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. All outputs are packed into one word
//   and compared each cycle against hand-written expected field values.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Func;
    logic       DMReady;
    logic       IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Retire, Illegal, MemFault;
    logic [2:0] RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp, DMType;
    logic [3:0] ALUOp;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .DMReady(DMReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .RegDstSel(RegDstSel),
        .ALUSrcSel(ALUSrcSel), .toRegSel(toRegSel), .NPCOp(NPCOp),
        .ALUOp(ALUOp), .EXTOp(EXTOp), .DMType(DMType), .Retire(Retire),
        .Illegal(Illegal), .MemFault(MemFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [29:0] obs;
    assign obs = {IRWrite, PCWrite, RegWrite, MemWrite, MemRead, Retire, Illegal, MemFault,
                  RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, DMType};

    // Field order: irw pcw rgw mw mr ret ill mf | rd as tr npc alu ext dmt
    function automatic logic [29:0] pk(input int irw, input int pcw, input int rgw,
                                       input int mw, input int mr, input int ret,
                                       input int ill, input int mf, input int rd,
                                       input int as, input int tr, input int npc,
                                       input int alu, input int ext, input int dmt);
        return {irw[0], pcw[0], rgw[0], mw[0], mr[0], ret[0], ill[0], mf[0],
                rd[2:0], as[2:0], tr[2:0], npc[2:0], alu[3:0], ext[2:0], dmt[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [29:0] e_zero, e_fetch, e_fault;

    initial begin
        e_zero  = pk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        e_fetch = pk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        e_fault = pk(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0);

        reset = 1'b0; Op = 6'd0; Func = 6'd0; DMReady = 1'b0;
        @(negedge clk); #1;
        chk("rst_outputs", obs, e_zero);

        // Test 1: add
        Op = 6'b000000; Func = 6'b100000;
        reset = 1'b1; #1;
        chk("add_c1_fetch", obs, e_fetch);
        step(); chk("add_c2_decode", obs, e_zero);
        step(); chk("add_c3_exec", obs, pk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        step(); chk("add_c4_wb", obs, pk(0,1,1,0,0,1,0,0, 1,0,0,0,0,0,0));
        step(); chk("add_next_fetch", obs, e_fetch);

        // sub
        Op = 6'b000000; Func = 6'b100010;
        step(); chk("sub_decode", obs, e_zero);
        step(); chk("sub_exec", obs, pk(0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        step(); chk("sub_wb", obs, pk(0,1,1,0,0,1,0,0, 1,0,0,0,1,0,0));
        step(); chk("sub_next_fetch", obs, e_fetch);

        // Test 2: lw with 3 wait cycles
        Op = 6'b100011; Func = 6'd0; DMReady = 1'b0;
        step(); chk("lw_decode", obs, e_zero);
        step(); chk("lw_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,1,0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("lw_mem%0d", i), obs, pk(0,0,0,0,1,0,0,0, 0,1,0,0,0,1,0));
            if (i == 3) DMReady = 1'b1;
        end
        step(); chk("lw_c8_wb", obs, pk(0,1,1,0,0,1,0,0, 0,0,1,0,0,0,0));
        DMReady = 1'b0;
        step(); chk("lw_next_fetch", obs, e_fetch);

        // lb with no wait
        Op = 6'b100000; DMReady = 1'b1;
        step(); chk("lb_decode", obs, e_zero);
        step(); chk("lb_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,1,0));
        step(); chk("lb_mem", obs, pk(0,0,0,0,1,0,0,0, 0,1,0,0,0,1,1));
        step(); chk("lb_wb", obs, pk(0,1,1,0,0,1,0,0, 0,0,1,0,0,0,1));
        step(); chk("lb_next_fetch", obs, e_fetch);

        // ori and lui
        Op = 6'b001101;
        step(); chk("ori_decode", obs, e_zero);
        step(); chk("ori_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,2,0,0));
        step(); chk("ori_wb", obs, pk(0,1,1,0,0,1,0,0, 0,1,0,0,2,0,0));
        step(); chk("ori_next_fetch", obs, e_fetch);
        Op = 6'b001111;
        step(); chk("lui_decode", obs, e_zero);
        step(); chk("lui_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,2,0));
        step(); chk("lui_wb", obs, pk(0,1,1,0,0,1,0,0, 0,1,2,0,0,2,0));
        step(); chk("lui_next_fetch", obs, e_fetch);

        // Test 3: jal, then j
        Op = 6'b000011;
        step(); chk("jal_decode", obs, e_zero);
        step(); chk("jal_c3_wb", obs, pk(0,1,1,0,0,1,0,0, 2,0,3,2,0,0,0));
        step(); chk("jal_next_fetch", obs, e_fetch);
        Op = 6'b000010;
        step(); chk("j_decode", obs, e_zero);
        step(); chk("j_wb", obs, pk(0,1,0,0,0,1,0,0, 0,0,0,2,0,0,0));
        step(); chk("j_next_fetch", obs, e_fetch);

        // beq and jr
        Op = 6'b000100;
        step(); chk("beq_decode", obs, e_zero);
        step(); chk("beq_exec", obs, pk(0,1,0,0,0,1,0,0, 0,0,0,1,1,1,0));
        step(); chk("beq_next_fetch", obs, e_fetch);
        Op = 6'b000000; Func = 6'b001000;
        step(); chk("jr_decode", obs, e_zero);
        step(); chk("jr_exec", obs, pk(0,1,0,0,0,1,0,0, 0,0,0,3,0,0,0));
        step(); chk("jr_next_fetch", obs, e_fetch);

        // Test 4: illegal opcode
        Op = 6'b111111; Func = 6'd0;
        step(); chk("ill_decode", obs, pk(0,1,0,0,0,1,1,0, 0,0,0,0,0,0,0));
        step(); chk("ill_next_fetch", obs, e_fetch);

        // sw completing immediately; MemWrite drops the cycle after
        Op = 6'b101011; DMReady = 1'b1;
        step(); chk("sw_decode", obs, e_zero);
        step(); chk("sw_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,1,0));
        step(); chk("sw_mem_ready", obs, pk(0,1,0,1,0,1,0,0, 0,1,0,0,0,1,0));
        step(); chk("sw_next_fetch", obs, e_fetch);

        // Test 5: sw with DMReady stuck low -> FAULT after 15 MEM cycles
        DMReady = 1'b0;
        step(); chk("swto_decode", obs, e_zero);
        step(); chk("swto_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,1,0));
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("swto_mem%0d", i), obs, pk(0,0,0,1,0,0,0,0, 0,1,0,0,0,1,0));
        end
        step(); chk("fault_entry", obs, e_fault);
        DMReady = 1'b1;
        step(); chk("fault_hold1", obs, e_fault);
        step(); chk("fault_hold2", obs, e_fault);
        DMReady = 1'b0;

        // Reset clears FAULT
        #2 reset = 1'b0; #1;
        chk("fault_reset_zero", obs, e_zero);
        @(negedge clk);
        Op = 6'b101000; Func = 6'd0;
        reset = 1'b1; #1;
        chk("after_fault_fetch", obs, e_fetch);

        // Test 6: sb, reset in MEM
        step(); chk("sb_decode", obs, e_zero);
        step(); chk("sb_exec", obs, pk(0,0,0,0,0,0,0,0, 0,1,0,0,0,1,0));
        step(); chk("sb_mem", obs, pk(0,0,0,1,0,0,0,0, 0,1,0,0,0,1,1));
        #2 reset = 1'b0; #1;
        chk("sb_async_reset", obs, e_zero);
        step(); chk("sb_reset_held", obs, e_zero);
        Op = 6'b000000; Func = 6'b100000;
        reset = 1'b1; #1;
        chk("sb_release_fetch", obs, e_fetch);
        step(); chk("sb_release_decode", obs, e_zero);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
